// File: rtl/dmem_responder.sv
// ============================================================================
//  Module   : dmem_responder
//  Purpose  : Memory-side responder for the Memory-stage load/store port.
//             Accepts one word request at a time, holds req_ready low for
//             WAIT_CYCLES of modelled access latency, then commits a store or
//             reads a load on the edge entering the response cycle and
//             raises a one-cycle resp_valid strobe.
//  Ports    :
//    clk        in   1       clock, all state on the rising edge
//    rst        in   1       synchronous reset, active-high
//    req_valid  in   1       request present, held until accepted
//    req_we     in   1       1 = store, 0 = load
//    req_addr   in   ADDR_W  word address
//    req_wdata  in   DATA_W  store data
//    req_ready  out  1       a request can be accepted this cycle
//    resp_valid out  1       one-cycle response strobe
//    resp_rdata out  DATA_W  load data, or echoed store data
//    resp_err   out  1       response is for an out-of-range address
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_responder #(
   parameter int ADDR_W      = 10,
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              req_ready,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err
);

   localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_C   = (ADDR_W + 1)'(DEPTH);
   localparam logic [3:0]      WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [ADDR_W-1:0]   addr_q;
   logic                we_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   rdata_q;
   logic                err_q;

   // Storage powers up zeroed; rst deliberately leaves it alone.
   logic [DATA_W-1:0]   mem_q [DEPTH] = '{default: '0};

   logic                accept;
   logic                acc_fire;
   logic                acc_we;
   logic                acc_in_range;
   logic [ADDR_W-1:0]   acc_addr;
   logic [DATA_W-1:0]   acc_wdata;
   logic [IDX_W-1:0]    acc_idx;

   assign req_ready  = (state_q != ST_BUSY);
   assign accept     = req_valid & req_ready;
   assign resp_valid = (state_q == ST_RESP);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

   // With zero latency the access happens on the accepting edge itself, so
   // the array sees the live request; otherwise it sees the captured one.
   generate
      if (WAIT_CYCLES == 0) begin : g_direct
         assign acc_addr  = req_addr;
         assign acc_we    = req_we;
         assign acc_wdata = req_wdata;
      end else begin : g_captured
         assign acc_addr  = addr_q;
         assign acc_we    = we_q;
         assign acc_wdata = wdata_q;
      end
   endgenerate

   assign acc_in_range = ({1'b0, acc_addr} < DEPTH_C);
   assign acc_idx      = acc_addr[IDX_W-1:0];
   // Every edge that lands in RESP performs exactly one access; reset wins.
   assign acc_fire     = (state_d == ST_RESP) & ~rst;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE, ST_RESP: begin
            if (accept) begin
               if (WAIT_CYCLES == 0) begin
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_BUSY;
                  cnt_d   = WAIT_INIT;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            addr_q  <= req_addr;
            we_q    <= req_we;
            wdata_q <= req_wdata;
         end
         if (acc_fire) begin
            if (acc_we) begin
               rdata_q <= acc_wdata;
            end else if (acc_in_range) begin
               rdata_q <= mem_q[acc_idx];
            end else begin
               rdata_q <= '0;
            end
            err_q <= ~acc_in_range;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (acc_fire && acc_we && acc_in_range) begin
         mem_q[acc_idx] <= acc_wdata;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
//  Module   : tb_dmem_responder
//  Purpose  : Directed bench for dmem_responder. Instance A runs with two
//             wait cycles and a 512-word array; instance B runs with zero
//             wait cycles and a full 1024-word array. Expected responses are
//             queued when requests are driven and retired in order whenever
//             a DUT raises resp_valid.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dmem_responder;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic        chk_data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_a = 1'b1, rst_b = 1'b1;

   logic        a_valid = 1'b0, a_we = 1'b0;
   logic [9:0]  a_addr = '0;
   logic [31:0] a_wdata = '0;
   logic        a_ready, a_resp_valid, a_resp_err;
   logic [31:0] a_resp_rdata;

   logic        b_valid = 1'b0, b_we = 1'b0;
   logic [9:0]  b_addr = '0;
   logic [31:0] b_wdata = '0;
   logic        b_ready, b_resp_valid, b_resp_err;
   logic [31:0] b_resp_rdata;

   exp_t sb_a[$];
   exp_t sb_b[$];
   int   n_asserts = 0;
   int   n_fails   = 0;

   always #5 clk = ~clk;

   dmem_responder #(.ADDR_W(10), .DATA_W(32), .DEPTH(512), .WAIT_CYCLES(2)) u_dut_a (
      .clk        (clk),
      .rst        (rst_a),
      .req_valid  (a_valid),
      .req_we     (a_we),
      .req_addr   (a_addr),
      .req_wdata  (a_wdata),
      .req_ready  (a_ready),
      .resp_valid (a_resp_valid),
      .resp_rdata (a_resp_rdata),
      .resp_err   (a_resp_err)
   );

   dmem_responder #(.ADDR_W(10), .DATA_W(32), .DEPTH(1024), .WAIT_CYCLES(0)) u_dut_b (
      .clk        (clk),
      .rst        (rst_b),
      .req_valid  (b_valid),
      .req_we     (b_we),
      .req_addr   (b_addr),
      .req_wdata  (b_wdata),
      .req_ready  (b_ready),
      .resp_valid (b_resp_valid),
      .resp_rdata (b_resp_rdata),
      .resp_err   (b_resp_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance to the next falling edge and retire any responses seen there.
   task automatic cyc();
      exp_t e;
      @(negedge clk);
      if (a_resp_valid === 1'b1) begin
         chk("a_resp_expected", 32'(sb_a.size() != 0), 32'd1);
         if (sb_a.size() != 0) begin
            e = sb_a.pop_front();
            chk("a_resp_err", 32'(a_resp_err), 32'(e.err));
            if (e.chk_data) chk("a_resp_rdata", a_resp_rdata, e.rdata);
         end
      end
      if (b_resp_valid === 1'b1) begin
         chk("b_resp_expected", 32'(sb_b.size() != 0), 32'd1);
         if (sb_b.size() != 0) begin
            e = sb_b.pop_front();
            chk("b_resp_err", 32'(b_resp_err), 32'(e.err));
            if (e.chk_data) chk("b_resp_rdata", b_resp_rdata, e.rdata);
         end
      end
   endtask

   // Present a request on A and return at the falling edge of the cycle
   // after acceptance, with req_valid dropped.
   task automatic issue_a(input logic we, input logic [9:0] addr, input logic [31:0] wd);
      int n = 0;
      a_valid = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
      while (a_ready !== 1'b1 && n < 20) begin
         cyc();
         n++;
      end
      chk("a_accept_timeout", 32'(a_ready), 32'd1);
      cyc();
      a_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((sb_a.size() != 0 || sb_b.size() != 0) && n < 30) begin
         cyc();
         n++;
      end
      chk("drain_pending", 32'(sb_a.size() + sb_b.size()), 32'd0);
   endtask

   task automatic access_a(input logic we, input logic [9:0] addr, input logic [31:0] wd,
                           input logic [31:0] er, input logic ee, input logic cd);
      sb_a.push_back('{er, ee, cd});
      issue_a(we, addr, wd);
      drain();
   endtask

   initial begin
      // Reset: two cycles of rst on both instances.
      cyc();
      cyc();
      chk("a_rst_ready", 32'(a_ready), 32'd1);
      chk("a_rst_valid", 32'(a_resp_valid), 32'd0);
      chk("a_rst_rdata", a_resp_rdata, 32'd0);
      chk("a_rst_err", 32'(a_resp_err), 32'd0);
      chk("b_rst_ready", 32'(b_ready), 32'd1);
      chk("b_rst_valid", 32'(b_resp_valid), 32'd0);
      chk("b_rst_rdata", b_resp_rdata, 32'd0);
      rst_a = 1'b0;
      rst_b = 1'b0;
      cyc();
      chk("a_idle_ready", 32'(a_ready), 32'd1);
      chk("a_idle_valid", 32'(a_resp_valid), 32'd0);

      // Store then load with two wait cycles, timing checked on the store.
      sb_a.push_back('{32'h0000_00A5, 1'b0, 1'b1});
      issue_a(1'b1, 10'd3, 32'h0000_00A5);
      chk("a_st_ready_t1", 32'(a_ready), 32'd0);
      chk("a_st_valid_t1", 32'(a_resp_valid), 32'd0);
      cyc();
      chk("a_st_ready_t2", 32'(a_ready), 32'd0);
      chk("a_st_valid_t2", 32'(a_resp_valid), 32'd0);
      cyc();
      chk("a_st_valid_t3", 32'(a_resp_valid), 32'd1);
      chk("a_st_ready_t3", 32'(a_ready), 32'd1);
      chk("a_st_pending", 32'(sb_a.size()), 32'd0);
      cyc();
      chk("a_st_valid_drop", 32'(a_resp_valid), 32'd0);
      access_a(1'b0, 10'd3, 32'h0, 32'h0000_00A5, 1'b0, 1'b1);

      // Back-to-back: the load is accepted in the store's response cycle.
      sb_a.push_back('{32'h0000_0011, 1'b0, 1'b1});
      issue_a(1'b1, 10'd7, 32'h0000_0011);
      a_valid = 1'b1; a_we = 1'b0; a_addr = 10'd7; a_wdata = 32'h0;
      sb_a.push_back('{32'h0000_0011, 1'b0, 1'b1});
      chk("b2b_ready_t1", 32'(a_ready), 32'd0);
      cyc();
      chk("b2b_ready_t2", 32'(a_ready), 32'd0);
      cyc();
      chk("b2b_resp1_valid", 32'(a_resp_valid), 32'd1);
      chk("b2b_resp1_ready", 32'(a_ready), 32'd1);
      cyc();
      a_valid = 1'b0;
      chk("b2b_ready_t4", 32'(a_ready), 32'd0);
      chk("b2b_valid_t4", 32'(a_resp_valid), 32'd0);
      cyc();
      chk("b2b_ready_t5", 32'(a_ready), 32'd0);
      cyc();
      chk("b2b_resp2_valid", 32'(a_resp_valid), 32'd1);
      chk("b2b_resp2_pending", 32'(sb_a.size()), 32'd0);
      drain();

      // Out-of-range handling on the 512-word instance.
      access_a(1'b1, 10'd600, 32'h0000_DEAD, 32'h0, 1'b1, 1'b0);
      access_a(1'b0, 10'd600, 32'h0, 32'h0, 1'b1, 1'b1);
      access_a(1'b0, 10'd599, 32'h0, 32'h0, 1'b1, 1'b1);
      access_a(1'b0, 10'd88, 32'h0, 32'h0, 1'b0, 1'b1);
      access_a(1'b0, 10'd511, 32'h0, 32'h0, 1'b0, 1'b1);
      access_a(1'b0, 10'd512, 32'h0, 32'h0, 1'b1, 1'b1);

      // Reset while the store is in flight: no response, nothing committed.
      issue_a(1'b1, 10'd5, 32'h0000_1234);
      rst_a = 1'b1;
      cyc();
      rst_a = 1'b0;
      chk("rst_mid_ready", 32'(a_ready), 32'd1);
      chk("rst_mid_rdata", a_resp_rdata, 32'd0);
      for (int i = 0; i < 4; i++) begin
         chk("rst_mid_no_resp", 32'(a_resp_valid), 32'd0);
         cyc();
      end
      access_a(1'b0, 10'd5, 32'h0, 32'h0, 1'b0, 1'b1);

      // Zero-latency stream on B: four stores then four loads, one per cycle.
      for (int i = 0; i < 8; i++) begin
         b_valid = 1'b1;
         b_we    = (i < 4);
         b_addr  = 10'(i % 4);
         b_wdata = (i < 4) ? (32'hC0DE_0000 + 32'(i)) : 32'h0;
         sb_b.push_back('{32'hC0DE_0000 + 32'(i % 4), 1'b0, 1'b1});
         chk("stream_ready", 32'(b_ready), 32'd1);
         if (i > 0) chk("stream_valid", 32'(b_resp_valid), 32'd1);
         cyc();
      end
      b_valid = 1'b0;
      chk("stream_valid_last", 32'(b_resp_valid), 32'd1);
      chk("stream_pending", 32'(sb_b.size()), 32'd0);
      cyc();
      chk("stream_valid_end", 32'(b_resp_valid), 32'd0);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
      $finish;
   end

endmodule

`default_nettype wire
